// File: rtl/wildcard_pkg.sv
// Shared types and constants for the wildcard expander.
package wildcard_pkg;

  localparam int DEFAULT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/wildcard_expander.sv
// Expands a (value, don't-care) pattern into every matching word, in ascending order.
// Optional ordinal output enabled by defining WILDCARD_EXPANDER_IDX_EN.
module wildcard_expander
  import wildcard_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_val,
  input  logic [W-1:0] in_dc,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_word,
  output logic         out_last
`ifdef WILDCARD_EXPANDER_IDX_EN
  ,
  output logic [W-1:0] out_idx
`endif
);

  state_t       r_state;
  logic [W-1:0] r_val;
  logic [W-1:0] r_dc;
  logic [W-1:0] r_sub;

  logic         w_last;
  logic [W-1:0] w_subNext;

  // Subtract-and-mask walks the submasks of r_dc in ascending numeric order.
  assign w_last    = (r_sub == r_dc);
  assign w_subNext = (r_sub - r_dc) & r_dc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_val   <= '0;
      r_dc    <= '0;
      r_sub   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_state <= EMIT;
            r_val   <= in_val & ~in_dc;
            r_dc    <= in_dc;
            r_sub   <= '0;
          end
        end
        EMIT: begin
          if (out_rdy) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_sub <= w_subNext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs come straight off registers, so reset clears them without waiting for a clock.
  assign in_rdy   = (r_state == IDLE);
  assign out_vld  = (r_state == EMIT);
  assign out_word = r_val | r_sub;
  assign out_last = out_vld & w_last;

`ifdef WILDCARD_EXPANDER_IDX_EN
  logic [W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (r_state == IDLE) begin
      if (in_vld) begin
        r_idx <= '0;
      end
    end else if (out_rdy && !w_last) begin
      r_idx <= r_idx + W'(1);
    end
  end

  assign out_idx = r_idx;
`endif

endmodule

// File: doc/wildcard_expander.md
WILDCARD_EXPANDER -- requirements
Module: wildcard_expander

Interface
REQ-001 SHALL have parameter W, default 3, meaning the width of pattern and output word in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_vld, input, 1 bit: a pattern request is valid.
REQ-005 SHALL have port in_rdy, output, 1 bit: the block accepts a pattern; a transfer occurs when in_vld and in_rdy are both 1 at a clk edge.
REQ-006 SHALL have port in_val, input, W bits: the pattern's fixed-bit values.
REQ-007 SHALL have port in_dc, input, W bits: don't-care mask (1 = wildcard bit, equivalent to x in a casex item).
REQ-008 SHALL have port out_vld, output, 1 bit: out_word is valid.
REQ-009 SHALL have port out_rdy, input, 1 bit: the consumer accepts out_word; a transfer occurs when out_vld and out_rdy are both 1 at a clk edge.
REQ-010 SHALL have port out_word, output, W bits: one concrete word matching the accepted pattern.
REQ-011 SHALL have port out_last, output, 1 bit: out_word is the final word of the expansion.

Function
REQ-012 SHALL enumerate every concrete word matching (in_val, in_dc), each exactly once, in ascending numeric order.
REQ-013 SHALL latch in_val & ~in_dc and in_dc on an input transfer; in_val bits under in_dc SHALL be ignored.
REQ-014 SHALL implement a two-state FSM, IDLE and EMIT: IDLE goes to EMIT on an input transfer; EMIT goes to IDLE on an output transfer with out_last=1; otherwise the state holds.
REQ-015 SHALL drive in_rdy = 1 exactly when in IDLE and out_vld = 1 exactly when in EMIT; no input is accepted during EMIT.
REQ-016 SHALL present the first word with out_vld=1 in the cycle after the input transfer (latency 1).
REQ-017 SHALL form out_word = latched_val | sub, where sub is a W-bit submask of latched_dc that starts at 0.
REQ-018 SHALL advance sub on each output transfer as sub_next = (sub - latched_dc) & latched_dc, modulo 2^W.
REQ-019 SHALL assert out_last exactly when sub == latched_dc.
REQ-020 SHALL hold out_word, out_last and out_vld stable while out_vld=1 and out_rdy=0.
REQ-021 SHALL, for in_dc = 0, emit exactly one word with out_last=1.
REQ-022 SHALL, for in_dc all ones, emit 2^W words, 0 through 2^W-1; sub SHALL NOT wrap past the last word.
REQ-023 SHALL make in_rdy = 1 in the cycle after the last output transfer; back-to-back patterns therefore cost one idle cycle.

Reset
REQ-024 SHALL, while rst=1, force state to IDLE, sub to 0, latched registers to 0, out_vld to 0, out_word to 0, out_last to 0, and in_rdy to 1.
REQ-025 SHALL, on rst asserted mid-expansion, drop out_vld immediately (asynchronously) and discard the remaining words; nothing resumes after reset.

Configuration
REQ-026 SHALL, when WILDCARD_EXPANDER_IDX_EN is defined, add output port out_idx, W bits: the ordinal of out_word within the current expansion (0 for the first word, incremented per output transfer), reset 0, held with out_word.
REQ-027 SHALL, without WILDCARD_EXPANDER_IDX_EN, have no out_idx port and no ordinal counter.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, EMIT) and the default width constant in package wildcard_pkg.
REQ-029 SHALL be a single module with no sub-module; the submask step is inline logic.

Verification (W=3)
REQ-030 SHALL cover: val=001, dc=000 -> one word 001 with out_last=1; in_rdy=1 the following cycle.
REQ-031 SHALL cover: val=100, dc=001 -> 100, then 101 with out_last=1.
REQ-032 SHALL cover: val=111, dc=110 -> 001, 011, 101, 111; out_last only on 111, which shows masked val bits are ignored.
REQ-033 SHALL cover: dc=111 with out_rdy=0 for 2 cycles at word 011 -> 000 through 111 in order (8 words), with 011 held stable during the stall.
REQ-034 SHALL cover: rst pulsed while word 010 of dc=111 is presented -> out_vld=0 at once, in_rdy=1, and no further words after release.
REQ-035 SHALL cover, with WILDCARD_EXPANDER_IDX_EN: val=000, dc=011 -> out_idx 0,1,2,3 paired with words 000, 001, 010, 011.
